// File: rtl/ejector.sv
// Ejection stage of the deflection router: registers the four link flits and
// removes at most one flit addressed to this node into a small ejection FIFO.
module ejector #(
    parameter logic [2:0] MY_ROW = 3'd4,
    parameter logic [2:0] MY_COL = 3'd4,
    parameter int         DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             northad,
    input  logic [9:0]             southad,
    input  logic [9:0]             eastad,
    input  logic [9:0]             westad,
    input  logic                   n_vld,
    input  logic                   s_vld,
    input  logic                   e_vld,
    input  logic                   w_vld,
    output logic [9:0]             nad,
    output logic [9:0]             sad,
    output logic [9:0]             ead,
    output logic [9:0]             wad,
    output logic                   nad_vld,
    output logic                   sad_vld,
    output logic                   ead_vld,
    output logic                   wad_vld,
    output logic [9:0]             ej_flit,
    output logic                   ej_vld,
    input  logic                   ej_rdy,
    output logic [$clog2(DEPTH):0] ej_count,
    output logic [15:0]            ej_total
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    // Channel index order doubles as tie-break priority: 0 E, 1 W, 2 N, 3 S.
    logic [9:0]    in_flit [4];
    logic [3:0]    in_vld;

    logic [9:0]    ch_flit_q [4];
    logic [9:0]    ch_flit_d [4];
    logic [3:0]    ch_vld_q;
    logic [3:0]    ch_vld_d;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   total_q, total_d;

    logic [3:0]    eject_ok;
    logic [3:0]    gold_ok;
    logic [3:0]    cand;
    logic [1:0]    win_idx;
    logic          win_vld;
    logic          push;
    logic          pop;
    logic [9:0]    push_flit;

    assign in_flit[0] = eastad;
    assign in_flit[1] = westad;
    assign in_flit[2] = northad;
    assign in_flit[3] = southad;
    assign in_vld     = {s_vld, n_vld, w_vld, e_vld};

    always_comb begin
        eject_ok = '0;
        gold_ok  = '0;
        win_idx  = '0;
        win_vld  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eject_ok[i] = in_vld[i] && (in_flit[i][5:3] == MY_ROW)
                                    && (in_flit[i][2:0] == MY_COL);
            gold_ok[i]  = eject_ok[i] && in_flit[i][9];
        end
        cand = (gold_ok != '0) ? gold_ok : eject_ok;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx = 2'(i);
                win_vld = 1'b1;
            end
        end
    end

    // Fullness is judged on the registered count only, keeping ej_rdy off the push path.
    assign push      = win_vld && (count_q < FULL_CNT);
    assign push_flit = in_flit[win_idx];
    assign ej_vld    = (count_q != '0);
    assign pop       = ej_vld && ej_rdy;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ch_vld_d[i]  = in_vld[i];
            ch_flit_d[i] = in_vld[i] ? in_flit[i] : 10'd0;
            if (push && (win_idx == 2'(i))) begin
                ch_vld_d[i]  = 1'b0;
                ch_flit_d[i] = 10'd0;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        total_d  = push ? total_q + 16'd1 : total_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ch_flit_q[i] <= 10'd0;
            ch_vld_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) ch_flit_q[i] <= ch_flit_d[i];
            ch_vld_q <= ch_vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    // NOTE: FIFO storage has no reset; stale entries are never visible because ej_vld gates the head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_flit;
    end

    assign ead      = ch_flit_q[0];
    assign wad      = ch_flit_q[1];
    assign nad      = ch_flit_q[2];
    assign sad      = ch_flit_q[3];
    assign ead_vld  = ch_vld_q[0];
    assign wad_vld  = ch_vld_q[1];
    assign nad_vld  = ch_vld_q[2];
    assign sad_vld  = ch_vld_q[3];
    assign ej_flit  = mem_q[rd_ptr_q];
    assign ej_count = count_q;
    assign ej_total = total_q;

endmodule

// File: tb/tb_ejector.sv
// Directed self-checking bench for ejector (node 4/4, DEPTH 4) with
// hand-computed expectations.
module tb_ejector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  northad, southad, eastad, westad;
    logic        n_vld, s_vld, e_vld, w_vld;
    logic [9:0]  nad, sad, ead, wad;
    logic        nad_vld, sad_vld, ead_vld, wad_vld;
    logic [9:0]  ej_flit;
    logic        ej_vld;
    logic        ej_rdy;
    logic [2:0]  ej_count;
    logic [15:0] ej_total;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q [$];
    logic [9:0] f;
    logic [9:0] rf [4];

    ejector #(.MY_ROW(3'd4), .MY_COL(3'd4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
        .n_vld(n_vld), .s_vld(s_vld), .e_vld(e_vld), .w_vld(w_vld),
        .nad(nad), .sad(sad), .ead(ead), .wad(wad),
        .nad_vld(nad_vld), .sad_vld(sad_vld), .ead_vld(ead_vld), .wad_vld(wad_vld),
        .ej_flit(ej_flit), .ej_vld(ej_vld), .ej_rdy(ej_rdy),
        .ej_count(ej_count), .ej_total(ej_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        northad = '0; southad = '0; eastad = '0; westad = '0;
        n_vld = 0; s_vld = 0; e_vld = 0; w_vld = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_async_count", ej_count, 0);
        check("rst_async_ejvld", ej_vld, 0);
        check("rst_async_total", ej_total, 0);
        check("rst_async_vlds", {nad_vld, sad_vld, ead_vld, wad_vld}, 0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with random inputs.
        northad = 10'($urandom); southad = 10'($urandom);
        eastad  = 10'($urandom); westad  = 10'($urandom);
        {n_vld, s_vld, e_vld, w_vld} = 4'($urandom);
        ej_rdy = 1'($urandom);
        repeat (3) step();
        check("rst_vlds", {nad_vld, sad_vld, ead_vld, wad_vld}, 0);
        check("rst_data", {nad, sad, ead, wad}, 0);
        check("rst_ejvld", ej_vld, 0);
        check("rst_count", ej_count, 0);
        check("rst_total", ej_total, 0);

        // First ejection after reset release.
        rst = 1'b0;
        clear_in();
        ej_rdy = 0;
        eastad = 10'h024; e_vld = 1;
        step();
        check("first_ead_vld", ead_vld, 0);
        check("first_ead", ead, 0);
        check("first_ejvld", ej_vld, 1);
        check("first_ejflit", ej_flit, 10'h024);
        check("first_total", ej_total, 1);
        check("first_count", ej_count, 1);

        // Drain, and an extra pop while empty is ignored.
        clear_in();
        ej_rdy = 1;
        step();
        check("drain_count", ej_count, 0);
        step();
        check("pop_empty_count", ej_count, 0);

        // Golden north beats non-golden east.
        ej_rdy = 0;
        eastad = 10'h024; e_vld = 1;
        northad = 10'h224; n_vld = 1;
        step();
        check("prio_ejflit", ej_flit, 10'h224);
        check("prio_nad_vld", nad_vld, 0);
        check("prio_nad", nad, 0);
        check("prio_ead", ead, 10'h024);
        check("prio_ead_vld", ead_vld, 1);
        check("prio_total", ej_total, 2);

        // Two golden flits: west beats south by fixed order; east non-golden loses.
        clear_in();
        eastad = 10'h064; e_vld = 1;
        westad = 10'h2A4; w_vld = 1;
        southad = 10'h224; s_vld = 1;
        step();
        check("tie_wad_vld", wad_vld, 0);
        check("tie_sad", sad, 10'h224);
        check("tie_sad_vld", sad_vld, 1);
        check("tie_ead", ead, 10'h064);
        check("tie_count", ej_count, 2);

        // Mid-stream reset discards FIFO and channels.
        clear_in();
        apply_reset();
        step();
        check("postrst_count", ej_count, 0);
        check("postrst_vlds", {nad_vld, sad_vld, ead_vld, wad_vld}, 0);

        // Fill the FIFO with four flits, then a fifth is deflected.
        ej_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            eastad = 10'h024 | 10'(k << 6); e_vld = 1;
            step();
        end
        check("full_count", ej_count, 4);
        check("full_total", ej_total, 4);
        clear_in();
        westad = 10'h124; w_vld = 1;
        step();
        check("full_wad_vld", wad_vld, 1);
        check("full_wad", wad, 10'h124);
        check("full_total_hold", ej_total, 4);
        check("full_count_hold", ej_count, 4);
        check("full_head", ej_flit, 10'h024);

        // Pop two, then push and pop together for ten cycles (pointers wrap).
        clear_in();
        ej_rdy = 1;
        step();
        check("pp_head1", ej_flit, 10'h064);
        step();
        check("pp_count_start", ej_count, 2);
        exp_q.push_back(10'h0A4);
        exp_q.push_back(10'h0E4);
        for (int k = 0; k < 10; k++) begin
            f = 10'h024 | 10'(k << 6);
            southad = f; s_vld = 1;
            check("pp_head", ej_flit, exp_q[0]);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(f);
            check("pp_count", ej_count, 2);
            check("pp_sad_vld", sad_vld, 0);
        end
        check("pp_total", ej_total, 14);
        clear_in();
        for (int k = 0; k < 2; k++) begin
            check("pp_tail", ej_flit, exp_q[0]);
            void'(exp_q.pop_front());
            step();
        end
        check("pp_empty_vld", ej_vld, 0);
        check("pp_empty_count", ej_count, 0);

        // Non-local flits pass through unchanged.
        for (int i = 0; i < 4; i++)
            rf[i] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 6'h09};
        eastad = rf[0]; westad = rf[1]; northad = rf[2]; southad = rf[3];
        {e_vld, w_vld, n_vld, s_vld} = 4'hF;
        step();
        check("pass_ead", {ead_vld, ead}, {1'b1, rf[0]});
        check("pass_wad", {wad_vld, wad}, {1'b1, rf[1]});
        check("pass_nad", {nad_vld, nad}, {1'b1, rf[2]});
        check("pass_sad", {sad_vld, sad}, {1'b1, rf[3]});
        check("pass_count", ej_count, 0);
        check("pass_total", ej_total, 14);

        // Invalid channels register as empty even with local data present.
        eastad = 10'h3FF; northad = 10'h224; westad = 10'h024; southad = 10'h155;
        {e_vld, w_vld, n_vld, s_vld} = 4'h0;
        step();
        check("empty_data", {nad, sad, ead, wad}, 0);
        check("empty_vlds", {nad_vld, sad_vld, ead_vld, wad_vld}, 0);
        check("empty_total", ej_total, 14);

        // ej_total wraps after 65536 ejections.
        clear_in();
        apply_reset();
        ej_rdy = 1;
        eastad = 10'h024; e_vld = 1;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_total_max", ej_total, 16'hFFFF);
        step();
        check("wrap_total_zero", ej_total, 0);
        check("wrap_count", ej_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
